// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file controller.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, opcode/op encodings, vsel encodings,
// the latched instruction field struct, and decode helpers used in IDLE.
package regfile_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    WR_IMM = 3'd4,
    WR_REG = 3'd5
  } state_t;

  // Instruction classes
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // MOV-class sub-operations
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOV  = 2'b00;

  // ALU-class sub-operations
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // Register file data_in source
  localparam logic VSEL_IMM = 1'b1;
  localparam logic VSEL_C   = 1'b0;

  // Fields captured when an instruction is accepted (14 bits)
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
  } fields_t;

  // MOV accepts only MOVI and MOV; every ALU sub-op is legal.
  function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OPC_ALU) ||
           ((opcode == OPC_MOV) && ((op == OP_MOVI) || (op == OP_MOV)));
  endfunction

  // First busy state for a legal instruction.
  // MOV and MVN skip GET_A because their A operand is forced to zero.
  function automatic state_t entry_state(input logic [2:0] opcode, input logic [1:0] op);
    state_t s;
    if (opcode == OPC_MOV) begin
      s = (op == OP_MOVI) ? WR_IMM : GET_B;
    end else begin
      case (op)
        OP_ADD, OP_CMP, OP_AND: s = GET_A;
        OP_MVN:                 s = GET_B;
        default:                s = GET_A;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/vDFFE.sv
// Enable flop: holds its value unless en is high at a rising clk edge.
// Latency: 1 cycle from d to q when enabled.
// Backpressure: none; en alone gates capture.
//
// Ports: clk, reset (async active-high, clears q), en, d[n-1:0], q[n-1:0].
module vDFFE #(
  parameter int n = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Moore FSM sequencing register-file reads/writes for MOV and ALU instructions.
// Latency: busy cycles after start edge -- MOVI 1, MOV/MVN/CMP 3, ADD/AND 4.
// Backpressure: w=1 only in IDLE; start is ignored while w=0.
//
// Ports:
//   clk, reset           clock and async active-high reset
//   start                accept the presented instruction (IDLE only)
//   opcode, op, rn/rd/rm instruction fields, captured on accept
//   readnum, writenum    register file read/write addresses (0 when unused)
//   write                register file write enable
//   loada/loadb/loadc/loads  datapath register enables
//   asel                 force ALU A operand to zero
//   vsel                 data_in source: 1 = imm, 0 = C
//   w                    ready (IDLE)
//   err                  one-cycle pulse after an illegal start
module regfile_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] rn,
  input  logic [2:0] rd,
  input  logic [2:0] rm,
  output logic [2:0] readnum,
  output logic [2:0] writenum,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       vsel,
  output logic       w,
  output logic       err
);

  state_t  state;
  state_t  state_nxt;
  fields_t fields_in;
  fields_t fields_q;
  logic    accept;
  logic    is_cmp;
  logic    zero_a;

  assign accept    = (state == IDLE) && start;
  assign fields_in = '{opcode: opcode, op: op, rn: rn, rd: rd, rm: rm};

  // Fields are captured on every IDLE start, legal or not; an illegal start
  // never leaves IDLE, so the stale capture is never observed.
  vDFFE #(.n($bits(fields_t))) u_fields (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     (fields_in),
    .q     (fields_q)
  );

  // Decode of the in-flight instruction; opcode is checked too because
  // MOV and ADD share op=00.
  assign is_cmp = (fields_q.opcode == OPC_ALU) && (fields_q.op == OP_CMP);
  assign zero_a = ((fields_q.opcode == OPC_MOV) && (fields_q.op == OP_MOV)) ||
                  ((fields_q.opcode == OPC_ALU) && (fields_q.op == OP_MVN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // err is registered so it is a clean one-cycle pulse and stays low in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= accept && !is_legal(opcode, op);
    end
  end

  always_comb begin
    state_nxt = state;
    readnum   = 3'b000;
    writenum  = 3'b000;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    vsel      = VSEL_C;
    w         = 1'b0;

    case (state)
      IDLE: begin
        w = 1'b1;
        // Decode the live inputs: the field latch captures on this same edge.
        if (start && is_legal(opcode, op)) begin
          state_nxt = entry_state(opcode, op);
        end
      end
      GET_A: begin
        readnum   = fields_q.rn;
        loada     = 1'b1;
        state_nxt = GET_B;
      end
      GET_B: begin
        readnum   = fields_q.rm;
        loadb     = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        asel = zero_a;
        if (is_cmp) begin
          // Compare only updates status; nothing is written back.
          loads     = 1'b1;
          state_nxt = IDLE;
        end else begin
          loadc     = 1'b1;
          state_nxt = WR_REG;
        end
      end
      WR_IMM: begin
        writenum  = fields_q.rn;
        vsel      = VSEL_IMM;
        write     = 1'b1;
        state_nxt = IDLE;
      end
      WR_REG: begin
        writenum  = fields_q.rd;
        vsel      = VSEL_C;
        write     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [2:0] readnum, writenum;
  logic       write, loada, loadb, loadc, loads, asel, vsel, w, err;

  int total = 0;
  int bad   = 0;

  // Expected strobe vectors: {w, err, write, loada, loadb, loadc, loads, asel, vsel}
  localparam logic [8:0] ST_IDLE = 9'b100000000;
  localparam logic [8:0] ST_ERR  = 9'b110000000;
  localparam logic [8:0] ST_A    = 9'b000100000;
  localparam logic [8:0] ST_B    = 9'b000010000;
  localparam logic [8:0] ST_C    = 9'b000001000;
  localparam logic [8:0] ST_CA   = 9'b000001010;
  localparam logic [8:0] ST_S    = 9'b000000100;
  localparam logic [8:0] ST_WR   = 9'b001000000;
  localparam logic [8:0] ST_WI   = 9'b001000001;

  regfile_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .opcode   (opcode),
    .op       (op),
    .rn       (rn),
    .rd       (rd),
    .rm       (rm),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .vsel     (vsel),
    .w        (w),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] oc, input logic [1:0] o,
                       input logic [2:0] n, input logic [2:0] d, input logic [2:0] m);
    start  = s;
    opcode = oc;
    op     = o;
    rn     = n;
    rd     = d;
    rm     = m;
  endtask

  task automatic chk(input string tag, input logic [8:0] st,
                     input logic [2:0] rnum, input logic [2:0] wnum);
    logic [14:0] obs;
    logic [14:0] expv;
    obs  = {w, err, write, loada, loadb, loadc, loads, asel, vsel, readnum, writenum};
    expv = {st, rnum, wnum};
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0);
    #1;
    chk("reset_state", ST_IDLE, 3'd0, 3'd0);

    // Illegal start while reset is held must not pulse err.
    drive(1'b1, 3'b111, 2'b00, 3'd0, 3'd0, 3'd0);
    tick();
    chk("reset_holds_err_low", ST_IDLE, 3'd0, 3'd0);
    reset = 1'b0;
    drive(1'b0, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0);
    tick();
    chk("idle_after_reset", ST_IDLE, 3'd0, 3'd0);

    // MOVI rn=3
    drive(1'b1, 3'b110, 2'b10, 3'd3, 3'd0, 3'd0);
    tick();
    chk("movi_wr_imm", ST_WI, 3'd0, 3'd3);
    start = 1'b0;
    tick();
    chk("movi_done", ST_IDLE, 3'd0, 3'd0);

    // ADD rn=1 rm=2 rd=5; inputs change after acceptance
    drive(1'b1, 3'b101, 2'b00, 3'd1, 3'd5, 3'd2);
    tick();
    chk("add_get_a", ST_A, 3'd1, 3'd0);
    drive(1'b0, 3'b110, 2'b10, 3'd7, 3'd7, 3'd3);
    tick();
    chk("add_get_b_latched_rm", ST_B, 3'd2, 3'd0);
    tick();
    chk("add_exec", ST_C, 3'd0, 3'd0);
    tick();
    chk("add_wr_reg", ST_WR, 3'd0, 3'd5);
    tick();
    chk("add_done", ST_IDLE, 3'd0, 3'd0);

    // CMP rn=4 rm=6
    drive(1'b1, 3'b101, 2'b01, 3'd4, 3'd1, 3'd6);
    tick();
    chk("cmp_get_a", ST_A, 3'd4, 3'd0);
    start = 1'b0;
    tick();
    chk("cmp_get_b", ST_B, 3'd6, 3'd0);
    tick();
    chk("cmp_exec_loads", ST_S, 3'd0, 3'd0);
    tick();
    chk("cmp_done_no_write", ST_IDLE, 3'd0, 3'd0);

    // Illegal opcode 111
    drive(1'b1, 3'b111, 2'b00, 3'd1, 3'd1, 3'd1);
    tick();
    chk("illegal_opc_err", ST_ERR, 3'd0, 3'd0);
    start = 1'b0;
    tick();
    chk("illegal_opc_err_cleared", ST_IDLE, 3'd0, 3'd0);

    // Illegal MOV op 01
    drive(1'b1, 3'b110, 2'b01, 3'd2, 3'd2, 3'd2);
    tick();
    chk("illegal_mov_op01_err", ST_ERR, 3'd0, 3'd0);
    start = 1'b0;
    tick();
    chk("illegal_mov_op01_cleared", ST_IDLE, 3'd0, 3'd0);

    // MOV rm=5 rd=6
    drive(1'b1, 3'b110, 2'b00, 3'd0, 3'd6, 3'd5);
    tick();
    chk("mov_get_b", ST_B, 3'd5, 3'd0);
    start = 1'b0;
    tick();
    chk("mov_exec_asel", ST_CA, 3'd0, 3'd0);
    tick();
    chk("mov_wr_reg", ST_WR, 3'd0, 3'd6);
    tick();
    chk("mov_done", ST_IDLE, 3'd0, 3'd0);

    // Reset in the middle of ADD (GET_B)
    drive(1'b1, 3'b101, 2'b00, 3'd1, 3'd5, 3'd2);
    tick();
    chk("rst_add_get_a", ST_A, 3'd1, 3'd0);
    start = 1'b0;
    tick();
    chk("rst_add_get_b", ST_B, 3'd2, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_outputs", ST_IDLE, 3'd0, 3'd0);
    tick();
    chk("rst_held_no_write", ST_IDLE, 3'd0, 3'd0);
    reset = 1'b0;
    drive(1'b1, 3'b110, 2'b10, 3'd0, 3'd0, 3'd0);
    tick();
    chk("rst_then_movi_r0", ST_WI, 3'd0, 3'd0);
    start = 1'b0;
    tick();
    chk("rst_then_movi_done", ST_IDLE, 3'd0, 3'd0);

    // Back-to-back: MVN rm=7 rd=2, then MOVI rn=2 with start held high
    drive(1'b1, 3'b101, 2'b11, 3'd0, 3'd2, 3'd7);
    tick();
    chk("b2b_mvn_get_b", ST_B, 3'd7, 3'd0);
    drive(1'b1, 3'b110, 2'b10, 3'd2, 3'd0, 3'd0);
    tick();
    chk("b2b_mvn_exec_asel", ST_CA, 3'd0, 3'd0);
    tick();
    chk("b2b_mvn_wr_reg", ST_WR, 3'd0, 3'd2);
    tick();
    chk("b2b_ready", ST_IDLE, 3'd0, 3'd0);
    tick();
    chk("b2b_movi_wr_imm", ST_WI, 3'd0, 3'd2);
    start = 1'b0;
    tick();
    chk("b2b_done", ST_IDLE, 3'd0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
